// File: rtl/lcd_byte_writer_pkg.sv
// Shared types and constants for the LCD byte writer: FSM states, default bus timing, command codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_byte_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_E_HIGH    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_EXEC_WAIT = 3'd4,
    ST_DONE      = 3'd5
  } lcd_state_t;

  // Default timing in sm_clk cycles at 50 MHz.
  localparam int DEF_SETUP_CYC     = 2;
  localparam int DEF_E_HIGH_CYC    = 12;
  localparam int DEF_HOLD_CYC      = 2;
  localparam int DEF_EXEC_CYC      = 2000;
  localparam int DEF_LONG_EXEC_CYC = 82000;
  localparam int DEF_CNT_W         = 17;

  // HD44780 commands that need the long execution wait.
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Clear (0x01) and return-home (0x02/0x03, bit 0 is don't-care) take ~1.64 ms.
  function automatic logic is_long_cmd(input logic is_cmd, input logic [7:0] db);
    return is_cmd && ((db == LCD_CMD_CLEAR) || (db[7:1] == LCD_CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_byte_writer_delay_counter.sv
// Down-counter used to time each bus phase; zero flag marks the last cycle of a phase.
// Latency: load takes effect on the next edge; zero is a combinational decode of the count register.
// Backpressure: none; load has priority over counting down.
module lcd_byte_writer_delay_counter #(
  parameter int CNT_W = 17
) (
  input  logic             sm_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load a phase length minus one, then count down and park at zero.
  always_ff @(posedge sm_clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// Writes one byte to an HD44780-style 8-bit bus with setup/E-pulse/hold timing, then waits exec time.
// Latency: finished pulses SETUP+E_HIGH+HOLD+EXEC (or LONG_EXEC) cycles after the accepting edge.
// Backpressure: busy is high while a write is in flight; start pulses seen while busy are dropped.
module lcd_byte_writer
  import lcd_byte_writer_pkg::*;
#(
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int E_HIGH_CYC    = DEF_E_HIGH_CYC,
  parameter int HOLD_CYC      = DEF_HOLD_CYC,
  parameter int EXEC_CYC      = DEF_EXEC_CYC,
  parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       sm_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] DB_in,
  input  logic       is_command,
  output logic       busy,
  output logic       finished,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  // Counter reload values: a phase of N cycles is loaded with N-1.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYC - 1);

  lcd_state_t       state;
  logic             long_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  lcd_byte_writer_delay_counter #(
    .CNT_W(CNT_W)
  ) u_delay (
    .sm_clk  (sm_clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

  // Reload the delay counter on every phase entry with the length of the phase being entered.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = E_LD;
        end
      end
      ST_E_HIGH: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = long_q ? LONG_LD : EXEC_LD;
        end
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  // Phase sequencer with registered bus and handshake outputs; reset aborts any write in flight.
  always_ff @(posedge sm_clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      long_q   <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_db   <= 8'h00;
    end else begin
      lcd_rw <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          finished <= 1'b0;
          if (start) begin
            lcd_db <= DB_in;
            lcd_rs <= ~is_command;
            long_q <= is_long_cmd(is_command, DB_in);
            busy   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            lcd_e <= 1'b1;
            state <= ST_E_HIGH;
          end
        end
        ST_E_HIGH: begin
          if (cnt_zero) begin
            lcd_e <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            state <= ST_EXEC_WAIT;
          end
        end
        ST_EXEC_WAIT: begin
          if (cnt_zero) begin
            finished <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          finished <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          lcd_e    <= 1'b0;
          finished <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench: default-timing instance (long exec shortened to 8200) plus an all-ones timing instance.
// Latency: normal write 2016 cycles, clear/home 8216 cycles, small instance 4 cycles.
// Backpressure: checks that start while busy (including DONE) is dropped.
module tb_lcd_byte_writer;

  logic       sm_clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] DB_in;
  logic       is_command;
  logic       busy, finished, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;

  logic       s_start;
  logic       s_busy, s_finished, s_lcd_e, s_lcd_rs, s_lcd_rw;
  logic [7:0] s_lcd_db;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0, t0s, f1, fc;

  // Monitor results for the main instance.
  int   e_rise = 0;
  int   e_len  = 0;
  logic e_prev = 1'b0;
  logic [7:0] rise_db = 8'h00;
  logic rise_rs = 1'b0;
  int   fin_cnt = 0;
  logic rw_seen = 1'b0;
  logic s_rw_seen = 1'b0;

  always #5 sm_clk = ~sm_clk;

  always @(posedge sm_clk) cyc <= cyc + 1;

  lcd_byte_writer #(
    .SETUP_CYC(2), .E_HIGH_CYC(12), .HOLD_CYC(2),
    .EXEC_CYC(2000), .LONG_EXEC_CYC(8200), .CNT_W(17)
  ) dut (
    .sm_clk(sm_clk), .reset(reset), .start(start), .DB_in(DB_in),
    .is_command(is_command), .busy(busy), .finished(finished),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
  );

  lcd_byte_writer #(
    .SETUP_CYC(1), .E_HIGH_CYC(1), .HOLD_CYC(1),
    .EXEC_CYC(1), .LONG_EXEC_CYC(1), .CNT_W(1)
  ) dut_small (
    .sm_clk(sm_clk), .reset(reset), .start(s_start), .DB_in(DB_in),
    .is_command(is_command), .busy(s_busy), .finished(s_finished),
    .lcd_e(s_lcd_e), .lcd_rs(s_lcd_rs), .lcd_rw(s_lcd_rw), .lcd_db(s_lcd_db)
  );

  // Record E pulse position/width, bus value at E rise, finished pulses and any RW activity.
  always @(negedge sm_clk) begin
    if (lcd_e && !e_prev) begin
      e_rise  = cyc;
      rise_db = lcd_db;
      rise_rs = lcd_rs;
    end
    if (!lcd_e && e_prev) e_len = cyc - e_rise;
    e_prev = lcd_e;
    if (finished) fin_cnt = fin_cnt + 1;
    if (lcd_rw) rw_seen = 1'b1;
    if (s_lcd_rw) s_rw_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with t0 = that edge number.
  task automatic do_start(input logic [7:0] db, input logic cmd);
    start = 1'b1;
    DB_in = db;
    is_command = cmd;
    @(posedge sm_clk);
    #1 t0 = cyc;
    @(negedge sm_clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where finished is high, or reports a timeout after the budget.
  task automatic wait_fin(input int budget, input string tag);
    int n = 0;
    while (!finished && n < budget) begin
      @(negedge sm_clk);
      n++;
    end
    if (!finished) chk({tag, "_timeout"}, {31'd0, finished}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    s_start = 1'b0;
    DB_in = 8'h00;
    is_command = 1'b0;

    // Reset state
    @(negedge sm_clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fin", {31'd0, finished}, 32'd0);
    chk("rst_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_db", {24'd0, lcd_db}, 32'h00);
    reset = 1'b1;
    @(negedge sm_clk);

    // 1: data write 0x41; inputs changed after accept must not reach the bus
    do_start(8'h41, 1'b0);
    DB_in = 8'hFF;
    is_command = 1'b1;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_db", {24'd0, lcd_db}, 32'h41);
    chk("t1_rs", {31'd0, lcd_rs}, 32'd1);
    wait_fin(3000, "t1");
    chk("t1_lat", cyc - t0, 32'd2016);
    chk("t1_setup", e_rise - t0, 32'd2);
    chk("t1_elen", e_len, 32'd12);
    chk("t1_rise_db", {24'd0, rise_db}, 32'h41);
    chk("t1_rise_rs", {31'd0, rise_rs}, 32'd1);
    @(negedge sm_clk);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_idle_fin", {31'd0, finished}, 32'd0);
    DB_in = 8'h99;
    repeat (3) @(negedge sm_clk);
    chk("t1_idle_hold_db", {24'd0, lcd_db}, 32'h41);

    // 2: clear command (long), function-set 0x38 (normal), data 0x01 (normal), home 0x02 (long)
    do_start(8'h01, 1'b1);
    chk("t2_clr_rs", {31'd0, lcd_rs}, 32'd0);
    chk("t2_clr_db", {24'd0, lcd_db}, 32'h01);
    wait_fin(9000, "t2_clr");
    chk("t2_clr_lat", cyc - t0, 32'd8216);
    @(negedge sm_clk);
    do_start(8'h38, 1'b1);
    wait_fin(3000, "t2_38");
    chk("t2_38_lat", cyc - t0, 32'd2016);
    @(negedge sm_clk);
    do_start(8'h01, 1'b0);
    wait_fin(3000, "t2_d01");
    chk("t2_d01_lat", cyc - t0, 32'd2016);
    @(negedge sm_clk);
    do_start(8'h02, 1'b1);
    wait_fin(9000, "t2_home");
    chk("t2_home_lat", cyc - t0, 32'd8216);
    @(negedge sm_clk);

    // 3: second start at cycle 100 is dropped
    fc = fin_cnt;
    do_start(8'h41, 1'b0);
    repeat (99) @(negedge sm_clk);
    start = 1'b1;
    DB_in = 8'h42;
    @(negedge sm_clk);
    start = 1'b0;
    chk("t3_db", {24'd0, lcd_db}, 32'h41);
    wait_fin(3000, "t3");
    chk("t3_lat", cyc - t0, 32'd2016);
    repeat (5) @(negedge sm_clk);
    chk("t3_one_fin", fin_cnt - fc, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);

    // 4: async reset in E_HIGH, start held during reset, then a full write
    fc = fin_cnt;
    do_start(8'h41, 1'b0);
    repeat (5) @(negedge sm_clk);
    chk("t4_e_before", {31'd0, lcd_e}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t4_e", {31'd0, lcd_e}, 32'd0);
    chk("t4_db", {24'd0, lcd_db}, 32'h00);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    @(negedge sm_clk);
    chk("t4_start_in_rst", {31'd0, busy}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge sm_clk);
    do_start(8'h41, 1'b0);
    wait_fin(3000, "t4");
    chk("t4_lat", cyc - t0, 32'd2016);
    chk("t4_elen", e_len, 32'd12);
    @(negedge sm_clk);
    chk("t4_fin_cnt", fin_cnt - fc, 32'd1);

    // 5: start during DONE dropped; start in following IDLE cycle accepted.
    // Period = 2016 + 1 DONE cycle + 1 IDLE cycle = 2018.
    do_start(8'h41, 1'b0);
    wait_fin(3000, "t5a");
    f1 = cyc;
    start = 1'b1;
    DB_in = 8'h55;
    @(negedge sm_clk);
    chk("t5_gap_busy", {31'd0, busy}, 32'd0);
    chk("t5_done_drop_db", {24'd0, lcd_db}, 32'h41);
    DB_in = 8'h43;
    @(posedge sm_clk);
    #1 t0 = cyc;
    @(negedge sm_clk);
    start = 1'b0;
    chk("t5_busy2", {31'd0, busy}, 32'd1);
    chk("t5_db2", {24'd0, lcd_db}, 32'h43);
    wait_fin(3000, "t5b");
    chk("t5_period", cyc - f1, 32'd2018);
    @(negedge sm_clk);

    // 6: all-ones timing instance
    begin
      int elen = 0;
      int lat = -1;
      DB_in = 8'h5A;
      is_command = 1'b0;
      s_start = 1'b1;
      @(posedge sm_clk);
      #1 t0s = cyc;
      @(negedge sm_clk);
      s_start = 1'b0;
      chk("t6_db", {24'd0, s_lcd_db}, 32'h5A);
      chk("t6_rs", {31'd0, s_lcd_rs}, 32'd1);
      for (int i = 0; i < 8; i++) begin
        if (s_lcd_e) elen++;
        if (s_finished && lat < 0) lat = cyc - t0s;
        @(negedge sm_clk);
      end
      chk("t6_lat", lat, 32'd4);
      chk("t6_elen", elen, 32'd1);
      chk("t6_busy", {31'd0, s_busy}, 32'd0);
    end
    chk("rw_main", {31'd0, rw_seen}, 32'd0);
    chk("rw_small", {31'd0, s_rw_seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
